// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants.
// Register file geometry and the hardwired-zero register.
package riscv_pkg;

   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID/issue/writeback/kill bundle between the pipeline and the scoreboard.
// The master is the pipeline side; the slave is the scoreboard.
interface reg_scoreboard_if #(
   parameter int CNT_W = 16
);
   import riscv_pkg::*;

   logic                id_valid;
   logic [REG_AW-1:0]   id_rs1;
   logic [REG_AW-1:0]   id_rs2;
   logic                id_uses_rs1;
   logic                id_uses_rs2;
   logic [REG_AW-1:0]   id_rd;
   logic                id_regwrite;
   logic                id_long_lat;
   logic                issue;
   logic                wb_valid;
   logic [REG_AW-1:0]   wb_rd;
   logic                kill_valid;
   logic [REG_AW-1:0]   kill_rd;
   logic                stall;
   logic [NUM_REGS-1:0] pending;
   logic                err;
   logic [CNT_W-1:0]    stall_cycles;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
      output id_rd, id_regwrite, id_long_lat, issue,
      output wb_valid, wb_rd, kill_valid, kill_rd,
      input  stall, pending, err, stall_cycles
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
      input  id_rd, id_regwrite, id_long_lat, issue,
      input  wb_valid, wb_rd, kill_valid, kill_rd,
      output stall, pending, err, stall_cycles
   );

endinterface

// File: rtl/reg_scoreboard_sat_counter.sv
// Saturating up-counter for performance statistics.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // Next count: advance on inc unless already saturated.
   always_comb begin
      q_d = q_q;
      if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks outstanding long-latency destinations and stalls ID on RAW/WAW.
// Stall is derived only from registered state; clears take effect next cycle.
module reg_scoreboard
   import riscv_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   reg_scoreboard_if.slave   sb
);

   localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic                err_q;
   logic                err_d;
   logic                raw1;
   logic                raw2;
   logic                waw;
   logic                stall;
   logic                do_set;
   logic                wb_hit;
   logic                kill_hit;
   logic                wb_bad;
   logic                kill_bad;
   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic [CNT_W-1:0]    cnt;

   // Hazard detection against outstanding writes.
   always_comb begin
      raw1  = sb.id_uses_rs1 && (sb.id_rs1 != REG_X0) && pending_q[sb.id_rs1];
      raw2  = sb.id_uses_rs2 && (sb.id_rs2 != REG_X0) && pending_q[sb.id_rs2];
      waw   = sb.id_regwrite && (sb.id_rd != REG_X0) && pending_q[sb.id_rd];
      stall = sb.id_valid && (raw1 || raw2 || waw);
   end

   // Pending-bit set/clear and sticky protocol error.
   always_comb begin
      do_set   = sb.issue && sb.id_valid && sb.id_regwrite &&
                 sb.id_long_lat && (sb.id_rd != REG_X0) && !stall;
      wb_hit   = sb.wb_valid && (sb.wb_rd != REG_X0);
      kill_hit = sb.kill_valid && (sb.kill_rd != REG_X0);
      wb_bad   = wb_hit && !pending_q[sb.wb_rd];
      kill_bad = kill_hit && !pending_q[sb.kill_rd];
      set_vec  = do_set ? (ONE << sb.id_rd) : '0;
      clr_vec  = '0;
      if (wb_hit) begin
         clr_vec = clr_vec | (ONE << sb.wb_rd);
      end
      if (kill_hit) begin
         clr_vec = clr_vec | (ONE << sb.kill_rd);
      end
      // Set wins over a same-cycle clear of the same register.
      pending_d    = (pending_q & ~clr_vec) | set_vec;
      pending_d[0] = 1'b0;
      err_d = err_q || (sb.issue && stall) || wb_bad || kill_bad ||
              ((set_vec & clr_vec) != '0);
   end

   // Scoreboard state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   sat_counter #(
      .W   (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall),
      .q   (cnt)
   );

   assign sb.stall        = stall;
   assign sb.pending      = pending_q;
   assign sb.err          = err_q;
   assign sb.stall_cycles = cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
module tb_reg_scoreboard;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   reg_scoreboard_if #(.CNT_W(16)) sb ();

   reg_scoreboard #(
      .CNT_W (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      sb.id_valid    = 1'b0;
      sb.id_rs1      = '0;
      sb.id_rs2      = '0;
      sb.id_uses_rs1 = 1'b0;
      sb.id_uses_rs2 = 1'b0;
      sb.id_rd       = '0;
      sb.id_regwrite = 1'b0;
      sb.id_long_lat = 1'b0;
      sb.issue       = 1'b0;
      sb.wb_valid    = 1'b0;
      sb.wb_rd       = '0;
      sb.kill_valid  = 1'b0;
      sb.kill_rd     = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_long(input logic [4:0] rd);
      idle();
      sb.id_valid    = 1'b1;
      sb.id_rd       = rd;
      sb.id_regwrite = 1'b1;
      sb.id_long_lat = 1'b1;
      sb.issue       = 1'b1;
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pending", sb.pending, 32'h0);
      chk("rst_stall", {31'b0, sb.stall}, 32'h0);
      chk("rst_err", {31'b0, sb.err}, 32'h0);
      chk("rst_cnt", {16'b0, sb.stall_cycles}, 32'h0);
      rst = 1'b0;

      // RAW: load x5, dependent add stalls 4 cycles
      tick();
      issue_long(5'd5);
      #1;
      chk("raw_issue_nostall", {31'b0, sb.stall}, 32'h0);
      tick();
      idle();
      sb.id_valid    = 1'b1;
      sb.id_rs1      = 5'd5;
      sb.id_uses_rs1 = 1'b1;
      sb.id_rd       = 5'd6;
      sb.id_regwrite = 1'b1;
      #1;
      chk("raw_stall", {31'b0, sb.stall}, 32'h1);
      chk("raw_pending", sb.pending, 32'h0000_0020);
      repeat (3) tick();
      sb.wb_valid = 1'b1;
      sb.wb_rd    = 5'd5;
      #1;
      chk("raw_no_bypass", {31'b0, sb.stall}, 32'h1);
      tick();
      sb.wb_valid = 1'b0;
      #1;
      chk("raw_release", {31'b0, sb.stall}, 32'h0);
      chk("raw_pending_clr", sb.pending, 32'h0);
      chk("raw_cnt", {16'b0, sb.stall_cycles}, 32'd4);
      chk("raw_err", {31'b0, sb.err}, 32'h0);

      // WAW: x7 pending, addi rd=x7 with no source reads
      tick();
      issue_long(5'd7);
      tick();
      idle();
      sb.id_valid    = 1'b1;
      sb.id_rd       = 5'd7;
      sb.id_regwrite = 1'b1;
      #1;
      chk("waw_stall", {31'b0, sb.stall}, 32'h1);
      tick();
      chk("waw_hold", {31'b0, sb.stall}, 32'h1);
      sb.wb_valid = 1'b1;
      sb.wb_rd    = 5'd7;
      tick();
      sb.wb_valid = 1'b0;
      #1;
      chk("waw_release", {31'b0, sb.stall}, 32'h0);
      chk("waw_cnt", {16'b0, sb.stall_cycles}, 32'd6);

      // x0: never tracked, wb to x0 is not an error
      tick();
      issue_long(5'd0);
      sb.id_uses_rs1 = 1'b1;
      tick();
      idle();
      #1;
      chk("x0_pending", sb.pending, 32'h0);
      sb.id_valid    = 1'b1;
      sb.id_uses_rs1 = 1'b1;
      sb.wb_valid    = 1'b1;
      sb.wb_rd       = 5'd0;
      #1;
      chk("x0_nostall", {31'b0, sb.stall}, 32'h0);
      tick();
      idle();
      #1;
      chk("x0_err", {31'b0, sb.err}, 32'h0);

      // Kill, then a second kill of the same register is an error
      issue_long(5'd9);
      tick();
      idle();
      #1;
      chk("kill_set", sb.pending, 32'h0000_0200);
      sb.kill_valid = 1'b1;
      sb.kill_rd    = 5'd9;
      tick();
      #1;
      chk("kill_clr", sb.pending, 32'h0);
      chk("kill_err0", {31'b0, sb.err}, 32'h0);
      tick();
      idle();
      #1;
      chk("kill_err1", {31'b0, sb.err}, 32'h1);
      repeat (3) tick();
      chk("err_sticky", {31'b0, sb.err}, 32'h1);

      // Simultaneous wb x3 and kill x4
      issue_long(5'd3);
      tick();
      issue_long(5'd4);
      tick();
      idle();
      #1;
      chk("sim_set", sb.pending, 32'h0000_0018);
      sb.wb_valid   = 1'b1;
      sb.wb_rd      = 5'd3;
      sb.kill_valid = 1'b1;
      sb.kill_rd    = 5'd4;
      tick();
      idle();
      #1;
      chk("sim_clr", sb.pending, 32'h0);

      // Reset clears sticky error
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst2_err", {31'b0, sb.err}, 32'h0);
      chk("rst2_cnt", {16'b0, sb.stall_cycles}, 32'h0);

      // Issue while stalled: no set, error raised
      issue_long(5'd10);
      tick();
      issue_long(5'd11);
      sb.id_rs2      = 5'd10;
      sb.id_uses_rs2 = 1'b1;
      #1;
      chk("viol_stall", {31'b0, sb.stall}, 32'h1);
      tick();
      sb.issue = 1'b0;
      #1;
      chk("viol_noset", sb.pending, 32'h0000_0400);
      chk("viol_err", {31'b0, sb.err}, 32'h1);

      // Saturation: hold the stall well past 2^16 cycles
      repeat (65541) @(posedge clk);
      #2;
      chk("sat_cnt", {16'b0, sb.stall_cycles}, 32'h0000_FFFF);
      chk("sat_stall", {31'b0, sb.stall}, 32'h1);

      // Reset mid-operation drops outstanding entries
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst3_pending", sb.pending, 32'h0);
      chk("rst3_stall", {31'b0, sb.stall}, 32'h0);
      chk("rst3_cnt", {16'b0, sb.stall_cycles}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
